fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo2 instance between N producers. Each producer presents a request and a data word. The arbiter grants one owner at a time and drives the FIFO write port. Burst-limited ownership keeps sharing fair, and FIFO full back-pressure stalls the owner without losing its slot.

Parameters:
SIZE, 2, data word width; must match the SIZE of the attached FIFO.
N_LOG2, 2, log2 of requester count; N = 2**N_LOG2.
MAX_BURST, 2, max transfers per grant; 1..255.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high.
req  input  N  per-requester write request; level, held until acked.
req_data  input  N*SIZE  flattened data; requester k occupies bits [k*SIZE +: SIZE].
ack  output  N  one-hot or zero; ack[k]=1 means requester k's word is written this cycle.
fifo_write  output  1  to FIFO write.
fifo_item  output  SIZE  to FIFO item_in.
fifo_full  input  1  from FIFO full.
busy  output  1  1 while state is OWN.

Behaviour:
- Reset: asynchronous. state=IDLE, owner=0, rr_ptr=0, burst_cnt=0. Outputs busy=0, ack=0, fifo_write=0, fifo_item=0.
- States: IDLE, OWN.
- IDLE, any req set:
  - Pick the first set req scanning from rr_ptr upward, wrapping mod N.
  - Register owner, clear burst_cnt, go to OWN.
  - Arbitration latency is 1 cycle; no write occurs in IDLE.
- OWN outputs (combinational from registered owner):
  - xfer = req[owner] & !fifo_full.
  - fifo_write = xfer; ack[owner] = xfer; all other ack bits 0.
  - fifo_item = req_data slice of owner (0 in IDLE).
- OWN burst counting: burst_cnt increments on each xfer. burst_cnt is 8 bits and never exceeds MAX_BURST.
- OWN release occurs when either:
  - req[owner]==0; or
  - xfer occurs with burst_cnt==MAX_BURST-1.
- On release: state<=IDLE, rr_ptr<=owner+1 (wraps naturally at N_LOG2 bits). One idle bubble cycle precedes the next grant.
- fifo_full in OWN: no xfer, no ack. Owner and burst_cnt hold, no release; a stall never counts toward the burst.
- Requests changing in IDLE: req bits dropping in the same cycle as arbitration are ignored; selection uses current-cycle req only.
- Fairness: a continuously requesting k waits at most (N-1)*(MAX_BURST+1) non-stalled cycles between grants.
- Reset mid-OWN: fifo_write and ack drop immediately (asynchronous). No partial state survives reset.

Optional Feature:
FIFO_ARB_LOCK_EN
- Defined:
  - Adds input req_last (N bits).
  - Ownership is packet-locked: MAX_BURST is ignored.
  - Owner releases only on an xfer with req_last[owner]=1.
  - A req[owner] drop mid-packet stalls (no release).
- Undefined: port absent; burst-limit release as above.

Decomposition:
- Package fifo_arb_pkg:
  - state encoding constants ST_IDLE=0, ST_OWN=1;
  - burst counter width constant (8).
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: req[N], rr_ptr[N_LOG2].
  - Outputs: idx[N_LOG2], valid.

Test Plan:
- Reset: assert reset with req=4'b1111 -> ack=0, fifo_write=0, busy=0. After release, the first grant goes to requester 0 on cycle 2.
- Single requester, N=4, MAX_BURST=2: req=4'b0100, data 2'b10, fifo_full=0.
  - Expected pattern: IDLE, write, write, IDLE, write, write...
  - ack[2] toggles 0,1,1,0,1,1; fifo_item=2'b10 on writes.
- All requesting: req=4'b1111 -> owners in order 0,1,2,3,0, two writes each, one bubble between.
- Back-pressure: owner 1 after 1 transfer, fifo_full=1 for 3 cycles.
  - During stall: fifo_write=0, ack=0, busy=1.
  - After stall: exactly one more write, then release, rr_ptr=2.
- Early drop: owner 3 with req[3] cleared after 1 write -> release next cycle, rr_ptr wraps to 0.
- Mid-operation reset: assert reset asynchronously between clock edges during OWN -> fifo_write falls before the next edge, state=IDLE.
- FIFO_ARB_LOCK_EN: owner 0 sends 4 words with req_last on the 4th -> 4 consecutive writes despite MAX_BURST=2, then release.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants for the round-robin FIFO write arbiter.
package fifo_arb_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;
  localparam int         BURST_W = 8;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or above rr_ptr, wrapping mod N.
module rr_pick #(
  parameter  int N_LOG2 = 2,
  localparam int N      = 1 << N_LOG2
) (
  input  logic [N-1:0]      req,
  input  logic [N_LOG2-1:0] rr_ptr,
  output logic [N_LOG2-1:0] idx,
  output logic              valid
);

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[rr_ptr + N_LOG2'(i)]) begin
        idx   = rr_ptr + N_LOG2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among 2**N_LOG2 producers.
// Define FIFO_ARB_LOCK_EN for packet-locked ownership via the req_last input.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int SIZE      = 2,
  parameter  int N_LOG2    = 2,
  parameter  int MAX_BURST = 2,
  localparam int N         = 1 << N_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N*SIZE-1:0] req_data,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [N-1:0]      req_last,
`endif
  output logic [N-1:0]      ack,
  output logic              fifo_write,
  output logic [SIZE-1:0]   fifo_item,
  input  logic              fifo_full,
  output logic              busy
);

  logic [0:0]         state;
  logic [N_LOG2-1:0]  owner;
  logic [N_LOG2-1:0]  rr_ptr;
  logic [BURST_W-1:0] burst_cnt;
  logic [N_LOG2-1:0]  pick_idx;
  logic               pick_valid;
  logic               own;
  logic               xfer;
  logic               release_own;

  rr_pick #(.N_LOG2(N_LOG2)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign own  = (state == ST_OWN);
  assign xfer = own & req[owner] & ~fifo_full;

`ifdef FIFO_ARB_LOCK_EN
  // A dropped request mid-packet simply stalls; only the tagged last word frees the port.
  assign release_own = xfer & req_last[owner];
`else
  assign release_own = own & (~req[owner] |
                              (xfer & (burst_cnt == BURST_W'(MAX_BURST - 1))));
`endif

  // Outputs are combinational from the registered owner, so reset clears them at once.
  assign busy       = own;
  assign fifo_write = xfer;
  assign ack        = xfer ? (N'(1) << owner) : '0;
  assign fifo_item  = own ? req_data[int'(owner)*SIZE +: SIZE] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            burst_cnt <= '0;
            state     <= ST_OWN;
          end
        end
        default: begin
          if (xfer && (burst_cnt < BURST_W'(MAX_BURST)))
            burst_cnt <= burst_cnt + BURST_W'(1);
          if (release_own) begin
            state  <= ST_IDLE;
            rr_ptr <= owner + N_LOG2'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a cycle-level behavioural model and write log.
module tb_fifo_wr_arbiter;
  localparam int N         = 4;
  localparam int N_LOG2    = 2;
  localparam int SIZE      = 2;
  localparam int MAX_BURST = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*SIZE-1:0] req_data;
  logic [N-1:0]    ack;
  logic            fifo_write;
  logic [SIZE-1:0] fifo_item;
  logic            fifo_full;
  logic            busy;
`ifdef FIFO_ARB_LOCK_EN
  logic [N-1:0]    req_last;
`endif

  int vectors = 0;
  int miscompares = 0;
  int wr_log[$];

  // model state: is someone owning, who, next scan start, writes done in this grant
  bit m_own = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  fifo_wr_arbiter #(.SIZE(SIZE), .N_LOG2(N_LOG2), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
`ifdef FIFO_ARB_LOCK_EN
    .req_last   (req_last),
`endif
    .ack        (ack),
    .fifo_write (fifo_write),
    .fifo_item  (fifo_item),
    .fifo_full  (fifo_full),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_log(input string name, input int n, input logic [63:0] exp);
    check({name, "_len"}, wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++)
      check({name, "_owner"}, wr_log[i], {28'd0, exp[4*i +: 4]});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: inputs are stable from posedge+1 to the next posedge, so the
  // values seen at the negedge are exactly the ones the next edge will sample.
  initial begin
    logic [N-1:0]    e_ack;
    logic            e_wr;
    logic [SIZE-1:0] e_item;
    bit              wrote;
    bit              found;
    int              cand;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_own = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      end
      e_ack = '0; e_wr = 1'b0; e_item = '0;
      wrote = m_own && req[m_owner] && !fifo_full;
      if (m_own) e_item = req_data[m_owner*SIZE +: SIZE];
      if (wrote) begin e_wr = 1'b1; e_ack[m_owner] = 1'b1; end
      check("ack", ack, e_ack);
      check("fifo_write", fifo_write, e_wr);
      check("fifo_item", fifo_item, e_item);
      check("busy", busy, m_own);
      for (int k = 0; k < N; k++)
        if (fifo_write && ack[k]) wr_log.push_back(k);
      if (!reset) begin
        if (!m_own) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            cand = (m_ptr + k) % N;
            if (!found && req[cand]) begin
              found = 1; m_own = 1; m_owner = cand; m_cnt = 0;
            end
          end
        end else begin
          if (wrote) m_cnt++;
`ifdef FIFO_ARB_LOCK_EN
          if (wrote && req_last[m_owner]) begin
`else
          if (!req[m_owner] || (wrote && m_cnt == MAX_BURST)) begin
`endif
            m_own = 0;
            m_ptr = (m_owner + 1) % N;
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] ack2_pat;
    ack2_pat = 6'b110110;
    reset = 1'b1; req = 4'b1111; req_data = 8'hE4; fifo_full = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
    req_last = '0;
`endif
    step(2);
    check("rst_ack", ack, 4'b0000);
    check("rst_write", fifo_write, 1'b0);
    check("rst_busy", busy, 1'b0);

`ifndef FIFO_ARB_LOCK_EN
    // all requesting: two writes per owner, one bubble between grants
    reset = 1'b0; wr_log.delete();
    #1 check("first_cycle_idle", busy, 1'b0);
    step(15);
    check_log("all_rr", 10, 64'h0033221100);

    // single requester 2
    req = 4'b0100;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("single_ack2", ack[2], ack2_pat[i]);
      if (ack2_pat[i]) check("single_item", fifo_item, 2'b10);
      step(1);
    end

    // back-pressure on owner 1 after its first write
    req = 4'b0010; wr_log.delete();
    step(2);
    fifo_full = 1'b1; req = 4'b1111;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_write", fifo_write, 1'b0);
      check("stall_ack", ack, 4'b0000);
      check("stall_busy", busy, 1'b1);
      step(1);
    end
    fifo_full = 1'b0;
    step(3);
    check_log("backpressure", 3, 64'h211);

    // early drop by owner 3
    step(2);
    wr_log.delete();
    step(1);
    req = 4'b0011;
    step(1);
    check("drop_bubble", busy, 1'b0);
    step(2);
    check_log("drop_wrap", 2, 64'h03);

    // asynchronous reset between edges while owning
    check("mid_write_before", fifo_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_write", fifo_write, 1'b0);
    check("mid_rst_ack", ack, 4'b0000);
    check("mid_rst_busy", busy, 1'b0);
    step(2);
`endif
    reset = 1'b0; req = 4'b0000;
    step(1);

    // owner 0 streams; packet-locked build tags the 4th word as last
    req = 4'b0001; wr_log.delete();
    step(4);
`ifdef FIFO_ARB_LOCK_EN
    req_last = 4'b0001;
`endif
    step(1);
`ifdef FIFO_ARB_LOCK_EN
    check("lock_busy_after", busy, 1'b0);
    check_log("lock_pkt", 4, 64'h0000);
    req_last = 4'b0000;
`else
    check("burst_busy_after", busy, 1'b1);
    check_log("burst_regrant", 3, 64'h000);
`endif
    req = 4'b0000;
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
